hc_csr_bank: RTL and testbench

//  Parametrised MMIO CSR bank for HardCloud AFUs. It sits between FIU and AFU on the CCI-P MMIO path.

---
 rtl/hc_pkg.sv | 65 ++++++
 rtl/hc_mmio_rsp_mux.sv | 43 ++++
 rtl/hc_csr_bank.sv | 167 ++++++++++++++++
 tb/tb_hc_csr_bank.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_pkg.sv
// Shared types and offsets for the HardCloud CSR bank and its response merge.
// Latency: n/a (types, constants and one constant-foldable helper only).
// Backpressure: n/a.
//
// Also carries the subset of the CCI-P MMIO channel types that the bank uses.
// The data field is narrowed to the 64 bits that the CSR path needs.
package hc_pkg;

    localparam int HC_BUFFER_MAX = 32;

    typedef logic [57:0] t_hc_address;   // byte address >> 6 (cache-line address)
    typedef logic [31:0] t_hc_control;

    typedef struct packed {
        t_hc_address address;
        logic [31:0] size;
    } t_hc_buffer;

    typedef enum logic [1:0] {
        HC_IDLE    = 2'd0,
        HC_RUNNING = 2'd1,
        HC_DONE    = 2'd2
    } t_hc_job_state;

    // CSR byte offsets
    localparam logic [11:0] HC_CSR_DFH       = 12'h000;
    localparam logic [11:0] HC_CSR_AFU_ID_L  = 12'h008;
    localparam logic [11:0] HC_CSR_AFU_ID_H  = 12'h010;
    localparam logic [11:0] HC_CSR_DSM_BASE  = 12'h100;
    localparam logic [11:0] HC_CSR_CONTROL   = 12'h108;
    localparam logic [11:0] HC_CSR_STATUS    = 12'h110;
    localparam logic [11:0] HC_CSR_DOORBELL  = 12'h118;
    localparam logic [11:0] HC_CSR_CYCLES    = 12'h120;
    localparam logic [11:0] HC_CSR_JOBS      = 12'h128;
    localparam logic [11:0] HC_CSR_BUF_BASE  = 12'h200;

    // MMIO channel subset
    typedef struct packed {
        logic [15:0] address;   // dword address
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    // Byte offset to the dword address carried in the MMIO header.
    function automatic logic [15:0] hc_dw(input logic [11:0] byte_off);
        return {4'd0, byte_off} >> 2;
    endfunction

endpackage

// File: rtl/hc_mmio_rsp_mux.sv
// Purpose: merge CSR read responses with AFU MMIO responses onto one c2Tx channel.
// Latency: 1 cycle (registered output); a colliding AFU response is delayed one more cycle via a 1-entry skid.
// Backpressure: none upstream; CSR wins, loser waits in skid; a collision with a full skid drops the AFU response.
//
// Ports: clk, reset (sync, active-high), csr_rsp / afu_rsp in, fiu_rsp out (registered).
module hc_mmio_rsp_mux
    import hc_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  t_if_ccip_c2_Tx csr_rsp,
    input  t_if_ccip_c2_Tx afu_rsp,
    output t_if_ccip_c2_Tx fiu_rsp
);

    t_if_ccip_c2_Tx skid_q;   // skid_q.mmioRdValid doubles as the occupancy flag

    always_ff @(posedge clk) begin
        if (reset) begin
            fiu_rsp <= '0;
            skid_q  <= '0;
        end else begin
            if (csr_rsp.mmioRdValid) begin
                fiu_rsp <= csr_rsp;
                // Park the AFU response only if the skid has room; otherwise it is lost.
                if (afu_rsp.mmioRdValid && !skid_q.mmioRdValid) begin
                    skid_q <= afu_rsp;
                end
            end else if (skid_q.mmioRdValid) begin
                fiu_rsp <= skid_q;
                // Skid drains this cycle, so a fresh AFU response can take its place.
                skid_q  <= afu_rsp;
            end else begin
                fiu_rsp <= afu_rsp;
            end
        end
    end

    // An AFU must not issue a response that collides while the skid still holds one.
    a_no_skid_overflow : assert property (@(posedge clk) disable iff (reset)
        !(csr_rsp.mmioRdValid && afu_rsp.mmioRdValid && skid_q.mmioRdValid));

endmodule

// File: rtl/hc_csr_bank.sv
// Purpose: MMIO CSR bank (DFH/AFU_ID, DSM base, control, buffer descriptors, status, doorbell) plus job FSM.
// Latency: writes take effect 2 edges after mmio_rx; reads answer 2 cycles after request; AFU responses 1 cycle.
// Backpressure: none; CSR responses preempt AFU responses, which are held in a 1-entry skid.
//
// Ports: clk, reset (sync, active-high); mmio_rx (FIU c0Rx), afu_c2tx (AFU responses), fiu_c2tx (merged);
//        job_done/job_err pulses in; hc_start pulse, hc_control, hc_dsm_base, hc_buffer[] out.
// Optional: define HC_CSR_PERF_CNT_EN to add CYCLES (0x120) and JOBS (0x128) counters; otherwise they read 0.
module hc_csr_bank
    import hc_pkg::*;
#(
    parameter int           N_BUFFERS = 4,
    parameter logic [127:0] AFU_ID    = 128'hC000C966_0D82_4272_9AEF_FE5F84570612,
    parameter logic [63:0]  DFH_VALUE = 64'h1000000010000000
) (
    input  logic           clk,
    input  logic           reset,
    input  t_if_ccip_c0_Rx mmio_rx,
    input  t_if_ccip_c2_Tx afu_c2tx,
    output t_if_ccip_c2_Tx fiu_c2tx,
    input  logic           job_done,
    input  logic           job_err,
    output logic           hc_start,
    output t_hc_control    hc_control,
    output t_hc_address    hc_dsm_base,
    output t_hc_buffer     hc_buffer [N_BUFFERS]
);

    t_if_ccip_c0_Rx rx_q;
    t_hc_job_state  state;
    logic           err_q;
    logic           overrun_q;

    logic [15:0]    addr;
    logic           in_csr;
    logic           wr;
    logic           is_buf;
    logic [4:0]     buf_idx;
    logic           doorbell_wr;
    logic           status_wr;
    logic           launch;
    logic [63:0]    rd_data;
    t_if_ccip_c2_Tx csr_rsp;

    // Single input register stage; all decode works on the registered request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q <= '0;
        end else begin
            rx_q <= mmio_rx;
        end
    end

    assign addr        = rx_q.hdr.address;
    assign in_csr      = addr < 16'h0400;
    assign wr          = rx_q.mmioWrValid && in_csr;
    // Buffer window: dwords 0x80..0xFF, 4 dwords per descriptor, 64b aligned only.
    assign is_buf      = (addr[15:7] == 9'd1) && !addr[0];
    assign buf_idx     = addr[6:2];
    assign doorbell_wr = wr && (addr == hc_dw(HC_CSR_DOORBELL));
    assign status_wr   = wr && (addr == hc_dw(HC_CSR_STATUS));
    assign launch      = doorbell_wr && (state == HC_IDLE);

    // RW registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_dsm_base <= '0;
            hc_control  <= '0;
            for (int i = 0; i < N_BUFFERS; i++) begin
                hc_buffer[i] <= '0;
            end
        end else if (wr) begin
            if (addr == hc_dw(HC_CSR_DSM_BASE)) hc_dsm_base <= rx_q.data[63:6];
            if (addr == hc_dw(HC_CSR_CONTROL))  hc_control  <= rx_q.data[31:0];
            for (int i = 0; i < N_BUFFERS; i++) begin
                if (is_buf && buf_idx == 5'(i)) begin
                    if (addr[1]) hc_buffer[i].size    <= rx_q.data[31:0];
                    else         hc_buffer[i].address <= rx_q.data[63:6];
                end
            end
        end
    end

    // Job FSM and sticky status bits. A set on the same edge as a W1C clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HC_IDLE;
            hc_start  <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            hc_start <= launch;
            case (state)
                HC_IDLE:    if (launch)                         state <= HC_RUNNING;
                HC_RUNNING: if (job_done || job_err)            state <= HC_DONE;
                HC_DONE:    if (status_wr && rx_q.data[0])      state <= HC_IDLE;
                default:                                        state <= HC_IDLE;
            endcase

            if (doorbell_wr && state != HC_IDLE)   overrun_q <= 1'b1;
            else if (status_wr && rx_q.data[3])    overrun_q <= 1'b0;

            if (state == HC_RUNNING && job_err)    err_q <= 1'b1;
            else if (status_wr && rx_q.data[2])    err_q <= 1'b0;
        end
    end

`ifdef HC_CSR_PERF_CNT_EN
    logic [63:0] cycles_q;
    logic [31:0] jobs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q <= '0;
            jobs_q   <= '0;
        end else if (launch) begin
            cycles_q <= '0;
            jobs_q   <= jobs_q + 32'd1;
        end else if (state == HC_RUNNING) begin
            cycles_q <= cycles_q + 64'd1;
        end
    end
`endif

    // Read mux
    always_comb begin
        rd_data = '0;
        if (is_buf) begin
            for (int i = 0; i < N_BUFFERS; i++) begin
                if (buf_idx == 5'(i)) begin
                    rd_data = addr[1] ? {32'd0, hc_buffer[i].size}
                                      : {hc_buffer[i].address, 6'd0};
                end
            end
        end else begin
            case (addr)
                hc_dw(HC_CSR_DFH):      rd_data = DFH_VALUE;
                hc_dw(HC_CSR_AFU_ID_L): rd_data = AFU_ID[63:0];
                hc_dw(HC_CSR_AFU_ID_H): rd_data = AFU_ID[127:64];
                hc_dw(HC_CSR_DSM_BASE): rd_data = {hc_dsm_base, 6'd0};
                hc_dw(HC_CSR_CONTROL):  rd_data = {32'd0, hc_control};
                hc_dw(HC_CSR_STATUS):   rd_data = {60'd0, overrun_q, err_q,
                                                   state == HC_RUNNING, state == HC_DONE};
`ifdef HC_CSR_PERF_CNT_EN
                hc_dw(HC_CSR_CYCLES):   rd_data = cycles_q;
                hc_dw(HC_CSR_JOBS):     rd_data = {32'd0, jobs_q};
`endif
                default:                rd_data = '0;
            endcase
        end
    end

    always_comb begin
        csr_rsp             = '0;
        csr_rsp.mmioRdValid = rx_q.mmioRdValid && in_csr;
        csr_rsp.hdr.tid     = rx_q.hdr.tid;
        csr_rsp.data        = rd_data;
    end

    hc_mmio_rsp_mux u_rsp_mux (
        .clk     (clk),
        .reset   (reset),
        .csr_rsp (csr_rsp),
        .afu_rsp (afu_c2tx),
        .fiu_rsp (fiu_c2tx)
    );

endmodule

// File: tb/tb_hc_csr_bank.sv
module tb_hc_csr_bank;
    import hc_pkg::*;

    localparam int           N_BUF  = 4;
    localparam logic [127:0] AFU_ID = 128'hC000C966_0D82_4272_9AEF_FE5F84570612;
    localparam logic [63:0]  DFH    = 64'h1000000010000000;

    logic           clk = 1'b0;
    logic           reset;
    t_if_ccip_c0_Rx mmio_rx;
    t_if_ccip_c2_Tx afu_c2tx;
    t_if_ccip_c2_Tx fiu_c2tx;
    logic           job_done;
    logic           job_err;
    logic           hc_start;
    t_hc_control    hc_control;
    t_hc_address    hc_dsm_base;
    t_hc_buffer     hc_buffer [N_BUF];

    hc_csr_bank #(.N_BUFFERS(N_BUF), .AFU_ID(AFU_ID), .DFH_VALUE(DFH)) dut (
        .clk         (clk),
        .reset       (reset),
        .mmio_rx     (mmio_rx),
        .afu_c2tx    (afu_c2tx),
        .fiu_c2tx    (fiu_c2tx),
        .job_done    (job_done),
        .job_err     (job_err),
        .hc_start    (hc_start),
        .hc_control  (hc_control),
        .hc_dsm_base (hc_dsm_base),
        .hc_buffer   (hc_buffer)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (hc_start) start_cnt++;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (register file view) ----------------
    logic [63:0] m_dsm, m_ctrl;
    logic [63:0] m_baddr [HC_BUFFER_MAX];
    logic [63:0] m_bsize [HC_BUFFER_MAX];

    function automatic void model_reset();
        m_dsm = '0;
        m_ctrl = '0;
        for (int i = 0; i < HC_BUFFER_MAX; i++) begin
            m_baddr[i] = '0;
            m_bsize[i] = '0;
        end
    endfunction

    function automatic void model_write(input int off, input logic [63:0] d);
        int i;
        if (off == 'h100) m_dsm = d & ~64'h3F;
        else if (off == 'h108) m_ctrl = {32'd0, d[31:0]};
        else if (off >= 'h200 && off < 'h400 && off % 8 == 0) begin
            i = (off - 'h200) / 16;
            if (i < N_BUF) begin
                if (off % 16 == 0) m_baddr[i] = d & ~64'h3F;
                else               m_bsize[i] = {32'd0, d[31:0]};
            end
        end
    endfunction

    // Expected read value while the job FSM is idle and counters untouched.
    function automatic logic [63:0] model_read(input int off);
        int i;
        if (off == 'h000) return DFH;
        if (off == 'h008) return AFU_ID[63:0];
        if (off == 'h010) return AFU_ID[127:64];
        if (off == 'h100) return m_dsm;
        if (off == 'h108) return m_ctrl;
        if (off >= 'h200 && off < 'h400 && off % 8 == 0) begin
            i = (off - 'h200) / 16;
            if (i < N_BUF) return (off % 16 == 0) ? m_baddr[i] : m_bsize[i];
        end
        return 64'd0;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic mmio_write(input int off, input logic [63:0] d);
        mmio_rx.mmioWrValid = 1'b1;
        mmio_rx.hdr.address = 16'(off >> 2);
        mmio_rx.hdr.tid     = 9'd0;
        mmio_rx.data        = d;
        @(negedge clk);
        mmio_rx.mmioWrValid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_write(input int off, input logic [63:0] d);
        model_write(off, d);
        mmio_write(off, d);
    endtask

    task automatic mmio_read(input int off, input logic [8:0] tid,
                             output logic [63:0] data, output logic [8:0] rtid,
                             output int lat, output logic seen);
        int c0;
        mmio_rx.mmioRdValid = 1'b1;
        mmio_rx.hdr.address = 16'(off >> 2);
        mmio_rx.hdr.tid     = tid;
        c0 = cyc;
        @(negedge clk);
        mmio_rx.mmioRdValid = 1'b0;
        seen = 1'b0; data = '0; rtid = '0; lat = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (fiu_c2tx.mmioRdValid) begin
                seen = 1'b1;
                data = fiu_c2tx.data;
                rtid = fiu_c2tx.hdr.tid;
                lat  = cyc - c0;
            end
        end
    endtask

    task automatic rd_chk(input string tag, input int off, input logic [8:0] tid, input logic [63:0] exp);
        logic [63:0] d; logic [8:0] t; int lat; logic seen;
        mmio_read(off, tid, d, t, lat, seen);
        chk_eq({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk_eq({tag, "_lat"}, 64'(lat), 64'd2);
            chk_eq({tag, "_tid"}, 64'(t), 64'(tid));
            chk_eq({tag, "_data"}, d, exp);
        end
    endtask

    task automatic job_pulse(input logic d, input logic e);
        job_done = d;
        job_err  = e;
        @(negedge clk);
        job_done = 1'b0;
        job_err  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mmio_rx = '0;
        afu_c2tx = '0;
        job_done = 1'b0;
        job_err = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] d;
        logic [8:0]  t;
        int          lat, off, c0, s0;
        logic        seen;
        int          offs [12] = '{'h000, 'h008, 'h010, 'h018, 'h020, 'h100, 'h108,
                                   'h118, 'h130, 'h1F8, 'h20C, 'h3F8};

        do_reset();

        // reset state
        chk_eq("rst_start",   64'(hc_start), 64'd0);
        chk_eq("rst_ctrl",    64'(hc_control), 64'd0);
        chk_eq("rst_dsm",     64'(hc_dsm_base), 64'd0);
        chk_eq("rst_buf0",    64'(hc_buffer[0]), 64'd0);
        chk_eq("rst_rsp_vld", 64'(fiu_c2tx.mmioRdValid), 64'd0);
        rd_chk("rst_status", 'h110, 9'd1, 64'd0);

        // identity registers
        rd_chk("dfh",      'h000, 9'd5, DFH);
        rd_chk("afu_id_l", 'h008, 9'd6, AFU_ID[63:0]);
        rd_chk("afu_id_h", 'h010, 9'd7, AFU_ID[127:64]);

        // address and size registers
        do_write('h100, 64'h1000_0040);
        do_write('h20C, 64'hDEAD_BEEF_DEAD_BEEF);
        chk_eq("dsm_base", 64'(hc_dsm_base), 64'h40_0001);
        rd_chk("dsm_rb", 'h100, 9'd8, 64'h1000_0040);
        do_write('h238, 64'h800);
        chk_eq("buf3_size", 64'(hc_buffer[3].size), 64'h800);

        // randomized register traffic against the model
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    if ($urandom_range(0, 1) == 1) off = 'h200 + 8 * $urandom_range(0, 63);
                    else off = ($urandom_range(0, 1) == 1) ? 'h100 : 'h108;
                    do_write(off, {$urandom, $urandom});
                end
                1, 2: begin
                    if ($urandom_range(0, 1) == 1) off = 'h200 + 8 * $urandom_range(0, 63);
                    else off = offs[$urandom_range(0, 11)];
                    rd_chk($sformatf("rnd_rd_%0h", off), off, 9'($urandom), model_read(off));
                end
                default: begin
                    t = 9'($urandom);
                    d = {$urandom, $urandom};
                    afu_c2tx.mmioRdValid = 1'b1;
                    afu_c2tx.hdr.tid = t;
                    afu_c2tx.data = d;
                    c0 = cyc;
                    @(negedge clk);
                    afu_c2tx.mmioRdValid = 1'b0;
                    chk_eq("afu_pass_vld", 64'(fiu_c2tx.mmioRdValid), 64'd1);
                    chk_eq("afu_pass_tid", 64'(fiu_c2tx.hdr.tid), 64'(t));
                    chk_eq("afu_pass_dat", fiu_c2tx.data, d);
                    chk_eq("afu_pass_lat", 64'(cyc - c0), 64'd1);
                    @(negedge clk);
                end
            endcase
        end
        chk_eq("out_dsm",  64'(hc_dsm_base), m_dsm >> 6);
        chk_eq("out_ctrl", 64'(hc_control), m_ctrl);
        for (int i = 0; i < N_BUF; i++) begin
            chk_eq($sformatf("out_baddr%0d", i), 64'(hc_buffer[i].address), m_baddr[i] >> 6);
            chk_eq($sformatf("out_bsize%0d", i), 64'(hc_buffer[i].size), m_bsize[i]);
        end

        // reads outside the CSR window are left to the AFU
        mmio_read('h1000, 9'd2, d, t, lat, seen);
        chk_eq("afu_range_quiet", 64'(seen), 64'd0);

        // collision: AFU response meets the CSR response at the merge point
        mmio_rx.mmioRdValid = 1'b1;
        mmio_rx.hdr.address = 16'd0;
        mmio_rx.hdr.tid = 9'd3;
        c0 = cyc;
        @(negedge clk);
        mmio_rx.mmioRdValid = 1'b0;
        afu_c2tx.mmioRdValid = 1'b1;
        afu_c2tx.hdr.tid = 9'd9;
        afu_c2tx.data = 64'hA5A5_5A5A_0123_4567;
        @(negedge clk);
        afu_c2tx.mmioRdValid = 1'b0;
        chk_eq("coll_csr_vld", 64'(fiu_c2tx.mmioRdValid), 64'd1);
        chk_eq("coll_csr_tid", 64'(fiu_c2tx.hdr.tid), 64'd3);
        chk_eq("coll_csr_dat", fiu_c2tx.data, DFH);
        chk_eq("coll_csr_lat", 64'(cyc - c0), 64'd2);
        @(negedge clk);
        chk_eq("coll_afu_vld", 64'(fiu_c2tx.mmioRdValid), 64'd1);
        chk_eq("coll_afu_tid", 64'(fiu_c2tx.hdr.tid), 64'd9);
        chk_eq("coll_afu_dat", fiu_c2tx.data, 64'hA5A5_5A5A_0123_4567);
        chk_eq("coll_afu_lat", 64'(cyc - c0), 64'd3);
        @(negedge clk);
        chk_eq("coll_no_dup", 64'(fiu_c2tx.mmioRdValid), 64'd0);

        // job FSM
        s0 = start_cnt;
        mmio_write('h118, 64'd1);
        chk_eq("db_start_now", 64'(hc_start), 64'd1);
        @(negedge clk);
        chk_eq("db_start_once", 64'(start_cnt - s0), 64'd1);
        chk_eq("db_start_low", 64'(hc_start), 64'd0);
        rd_chk("st_running", 'h110, 9'd10, 64'h2);
        mmio_write('h118, 64'd1);
        @(negedge clk);
        chk_eq("db2_no_start", 64'(start_cnt - s0), 64'd1);
        rd_chk("st_overrun", 'h110, 9'd11, 64'hA);
        rd_chk("db_reads0", 'h118, 9'd12, 64'h0);
        job_pulse(1'b1, 1'b0);
        rd_chk("st_done", 'h110, 9'd13, 64'h9);
        mmio_write('h110, 64'h9);
        rd_chk("st_cleared", 'h110, 9'd14, 64'h0);

        mmio_write('h118, 64'd1);
        job_pulse(1'b1, 1'b1);
        rd_chk("st_done_err", 'h110, 9'd15, 64'h5);
        mmio_write('h110, 64'h5);
        job_pulse(1'b1, 1'b0);
        job_pulse(1'b0, 1'b1);
        rd_chk("st_idle_ignore", 'h110, 9'd16, 64'h0);

        // reset mid-job
        mmio_write('h108, 64'h55);
        mmio_write('h118, 64'd1);
        repeat (3) @(negedge clk);
        do_reset();
        chk_eq("rst_mid_ctrl", 64'(hc_control), 64'd0);
        chk_eq("rst_mid_start", 64'(hc_start), 64'd0);
        rd_chk("rst_mid_status", 'h110, 9'd17, 64'h0);

        // performance counters: 100 cycles in RUNNING
        mmio_write('h118, 64'd1);
        chk_eq("perf_start", 64'(hc_start), 64'd1);
        repeat (99) @(negedge clk);
        job_pulse(1'b1, 1'b0);
        repeat (5) @(negedge clk);
`ifdef HC_CSR_PERF_CNT_EN
        rd_chk("perf_cycles", 'h120, 9'd18, 64'd100);
        rd_chk("perf_jobs",   'h128, 9'd19, 64'd1);
`else
        rd_chk("perf_cycles", 'h120, 9'd18, 64'd0);
        rd_chk("perf_jobs",   'h128, 9'd19, 64'd0);
`endif
        rd_chk("perf_status", 'h110, 9'd20, 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
